// File: rtl/m1rstseq_pkg.sv
// m1rstseq shared definitions: FSM state encoding and reset-cause codes.
// Imported by m1rstseq and m1rstseq_sync.
package m1rstseq_pkg;

    localparam logic [1:0] ST_HOLD      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_TRIG = 2'd1;
    localparam logic [1:0] CAUSE_LOCK = 2'd2;

endpackage

// File: rtl/m1rstseq_sync.sv
// Multi-flop synchroniser, asynchronously cleared to 0.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronised out).
module m1rstseq_sync
    import m1rstseq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/m1rstseq.sv
// Multi-channel reset sequencer: hold, wait for PLL lock, release channels
// in index order REL_STEP apart, then release sys_rst.
// Ports: sys_clk, sys_rst_n (async), trigger_reset, pll_locked (async),
// ch_rst_n[N_CH] (active-low), sys_rst, busy.
// Option M1RSTSEQ_CAUSE_EN adds rst_cause[1:0] (0=POR, 1=trigger, 2=lock).
module m1rstseq
    import m1rstseq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 1048575,
    parameter int REL_STEP    = 128,
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            trigger_reset,
    input  logic            pll_locked,
    output logic [N_CH-1:0] ch_rst_n,
    output logic            sys_rst,
    output logic            busy
`ifdef M1RSTSEQ_CAUSE_EN
    ,
    output logic [1:0]      rst_cause
`endif
);

    localparam int IDX_W = $clog2(N_CH + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(REL_STEP - 1);
    localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(N_CH);
    localparam logic [N_CH-1:0]  CH_ONE    = N_CH'(1);

    logic             lock_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             restart;

    m1rstseq_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .d    (pll_locked),
        .q    (lock_s)
    );

    // Lock loss only matters once channels may have been released;
    // in WAIT_LOCK the block just keeps waiting.
    assign restart = trigger_reset
                   | (~lock_s & ((state == ST_RELEASE)
                               | (state == ST_RUN)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            idx      <= '0;
            ch_rst_n <= '0;
            sys_rst  <= 1'b1;
            busy     <= 1'b1;
        end else if (restart) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            idx      <= '0;
            ch_rst_n <= '0;
            sys_rst  <= 1'b1;
            busy     <= 1'b1;
        end else begin
            unique case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (cnt != STEP_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (idx == IDX_DONE) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        ch_rst_n <= ch_rst_n | (CH_ONE << idx);
                        idx      <= idx + 1'b1;
                        cnt      <= '0;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

`ifdef M1RSTSEQ_CAUSE_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_cause <= CAUSE_POR;
        end else if (restart) begin
            rst_cause <= trigger_reset ? CAUSE_TRIG : CAUSE_LOCK;
        end
    end
`endif

endmodule

// File: tb/tb_m1rstseq.sv
// Self-checking bench for m1rstseq: constant vector table, directed
// corner sequences and random stimulus against a timestamp model.
module tb_m1rstseq;

    localparam int N  = 3;
    localparam int HC = 16;
    localparam int RS = 4;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         trigger_reset;
    logic         pll_locked;
    logic [N-1:0] ch_rst_n;
    logic         sys_rst;
    logic         busy;
`ifdef M1RSTSEQ_CAUSE_EN
    logic [1:0]   rst_cause;
`endif

    m1rstseq #(
        .N_CH(N),
        .HOLD_CYCLES(HC),
        .REL_STEP(RS),
        .CNT_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .trigger_reset(trigger_reset),
        .pll_locked(pll_locked),
        .ch_rst_n(ch_rst_n),
        .sys_rst(sys_rst),
        .busy(busy)
`ifdef M1RSTSEQ_CAUSE_EN
        ,
        .rst_cause(rst_cause)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // Model: edge count since reset, edge where hold began, edge where
    // lock was accepted (-1 = not yet), lock inputs of last two edges.
    int         ecount;
    int         t0;
    int         r_edge;
    logic       p1, p2;
    logic [1:0] m_cause;

    typedef struct {
        int           edge_n;
        logic [N-1:0] ch;
        logic         sr;
        logic         bz;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s edge=%0d got=%0h exp=%0h",
                         nm, ecount, act, exp);
        end
    endtask

    task automatic model_reset();
        ecount  = 0;
        t0      = 0;
        r_edge  = -1;
        p1      = 1'b0;
        p2      = 1'b0;
        m_cause = 2'd0;
    endtask

    task automatic model_edge(input logic trig, input logic pll);
        logic lk;
        lk = p2;
        p2 = p1;
        p1 = pll;
        if (trig) begin
            t0 = ecount; r_edge = -1; m_cause = 2'd1;
        end else if (r_edge >= 0 && !lk) begin
            t0 = ecount; r_edge = -1; m_cause = 2'd2;
        end else if (r_edge < 0 && ecount > t0 + HC && lk) begin
            r_edge = ecount;
        end
    endtask

    task automatic check_model(input string nm);
        logic [N-1:0] ech;
        logic         esr;
        ech = '0;
        esr = 1'b1;
        if (r_edge >= 0) begin
            for (int k = 0; k < N; k++)
                if (ecount >= r_edge + (k + 1) * RS) ech[k] = 1'b1;
            if (ecount >= r_edge + (N + 1) * RS) esr = 1'b0;
        end
        chk({nm, ".ch_rst_n"}, 16'(ch_rst_n), 16'(ech));
        chk({nm, ".sys_rst"}, 16'(sys_rst), 16'(esr));
        chk({nm, ".busy"}, 16'(busy), 16'(esr));
`ifdef M1RSTSEQ_CAUSE_EN
        chk({nm, ".rst_cause"}, 16'(rst_cause), 16'(m_cause));
`endif
    endtask

    task automatic step(input logic trig, input logic pll);
        trigger_reset = trig;
        pll_locked    = pll;
        @(posedge sys_clk);
        ecount++;
        model_edge(trig, pll);
        #1;
        check_model("seq");
    endtask

    task automatic run_to(input int e, input logic pll);
        while (ecount < e) step(1'b0, pll);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".ch_rst_n"}, 16'(ch_rst_n), 16'h0);
        chk({nm, ".sys_rst"}, 16'(sys_rst), 16'h1);
        chk({nm, ".busy"}, 16'(busy), 16'h1);
`ifdef M1RSTSEQ_CAUSE_EN
        chk({nm, ".rst_cause"}, 16'(rst_cause), 16'h0);
`endif
    endtask

    // Called 1 time unit after a rising edge; asserts reset between edges.
    task automatic pulse_reset();
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge sys_clk);
        #1;
        chk_reset_vals("rst_held");
        #2;
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0] = '{1,  3'b000, 1'b1, 1'b1};
        tbl[1] = '{20, 3'b000, 1'b1, 1'b1};
        tbl[2] = '{21, 3'b001, 1'b1, 1'b1};
        tbl[3] = '{24, 3'b001, 1'b1, 1'b1};
        tbl[4] = '{25, 3'b011, 1'b1, 1'b1};
        tbl[5] = '{28, 3'b011, 1'b1, 1'b1};
        tbl[6] = '{29, 3'b111, 1'b1, 1'b1};
        tbl[7] = '{32, 3'b111, 1'b1, 1'b1};
        tbl[8] = '{33, 3'b111, 1'b0, 1'b0};
        tbl[9] = '{40, 3'b111, 1'b0, 1'b0};

        sys_rst_n     = 1'b0;
        trigger_reset = 1'b0;
        pll_locked    = 1'b1;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_vals("por");
        #2;
        sys_rst_n = 1'b1;

        // 1: power-on, lock stable
        for (int i = 0; i < 10; i++) begin
            run_to(tbl[i].edge_n, 1'b1);
            chk("tbl.ch_rst_n", 16'(ch_rst_n), 16'(tbl[i].ch));
            chk("tbl.sys_rst", 16'(sys_rst), 16'(tbl[i].sr));
            chk("tbl.busy", 16'(busy), 16'(tbl[i].bz));
        end

        // 3: one-cycle trigger in RUN, sequence repeats from pulse edge
        step(1'b1, 1'b1);
        chk("trig.ch_rst_n", 16'(ch_rst_n), 16'h0);
        chk("trig.sys_rst", 16'(sys_rst), 16'h1);
`ifdef M1RSTSEQ_CAUSE_EN
        chk("trig.cause", 16'(rst_cause), 16'h1);
`endif
        run_to(41 + 20, 1'b1);
        chk("trig.ch_pre", 16'(ch_rst_n), 16'h0);
        step(1'b0, 1'b1);
        chk("trig.ch0", 16'(ch_rst_n), 16'h1);
        run_to(41 + 33, 1'b1);
        chk("trig.run", 16'(busy), 16'h0);

        // 2: lock arrives late
        pulse_reset();
        run_to(39, 1'b0);
        run_to(45, 1'b1);
        chk("late.ch_pre", 16'(ch_rst_n), 16'h0);
        step(1'b0, 1'b1);
        chk("late.ch0", 16'(ch_rst_n), 16'h1);
        run_to(50, 1'b1);
        chk("late.ch1", 16'(ch_rst_n), 16'h3);
        run_to(54, 1'b1);
        chk("late.ch2", 16'(ch_rst_n), 16'h7);
        run_to(58, 1'b1);
        chk("late.sys_rst", 16'(sys_rst), 16'h0);

        // 5: trigger and lock loss together in RUN
        step(1'b1, 1'b0);
        chk("both.sys_rst", 16'(sys_rst), 16'h1);
`ifdef M1RSTSEQ_CAUSE_EN
        chk("both.cause", 16'(rst_cause), 16'h1);
`endif

        // 4: lock drop after ch0 released
        pulse_reset();
        run_to(22, 1'b1);
        run_to(24, 1'b0);
        chk("drop.ch_hold", 16'(ch_rst_n), 16'h1);
        step(1'b0, 1'b0);
        chk("drop.ch_rst_n", 16'(ch_rst_n), 16'h0);
        chk("drop.sys_rst", 16'(sys_rst), 16'h1);
`ifdef M1RSTSEQ_CAUSE_EN
        chk("drop.cause", 16'(rst_cause), 16'h2);
`endif
        run_to(60, 1'b0);
        run_to(90, 1'b1);

        // 6: async reset mid-HOLD and mid-RELEASE
        pulse_reset();
        run_to(8, 1'b1);
        pulse_reset();
        run_to(23, 1'b1);
        pulse_reset();
        run_to(32, 1'b1);
        chk("rerun.busy_pre", 16'(busy), 16'h1);
        step(1'b0, 1'b1);
        chk("rerun.busy", 16'(busy), 16'h0);

        // random stimulus against the model
        begin
            logic pll;
            logic trig;
            pll = 1'b1;
            for (int i = 0; i < 5000; i++) begin
                if ($urandom_range(0, 149) == 0) pll = ~pll;
                trig = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 1499) == 0)
                    pulse_reset();
                else
                    step(trig, pll);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
